// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package config_loader_pkg;

    localparam int unsigned CONFIG_BITS_PER_TILE = 29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/config_word_serializer.sv
// Word buffer and bit serialiser feeding the configuration shift chain.
// The output flops are the first stage of the stream: a bit is on the chain pins while it is counted as shifting.
module config_word_serializer
    import config_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned CHAIN_LENGTH = CONFIG_BITS_PER_TILE
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  clear,
    input  logic                  active,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  ready_c,
    output logic                  shift_bit,
    output logic                  shift_en,
    output logic                  last_shift_c
);

    localparam int unsigned LEFT_W  = $clog2(WORD_WIDTH + 1);
    localparam int unsigned TOTAL_W = $clog2(CHAIN_LENGTH + 1);

    logic [WORD_WIDTH-1:0] word_q;
    logic [LEFT_W-1:0]     bits_left_q;
    logic [TOTAL_W-1:0]    bits_queued_q;
    logic [TOTAL_W-1:0]    bits_total_q;
    logic [31:0]           remaining_c;
    logic [LEFT_W-1:0]     take_c;
    logic                  accept_c;

    // The final word only contributes the bits still needed to fill the chain.
    always_comb begin
        remaining_c = CHAIN_LENGTH - 32'(bits_queued_q);
        take_c      = (remaining_c >= WORD_WIDTH) ? LEFT_W'(WORD_WIDTH) : LEFT_W'(remaining_c);
    end

    // Accepting while the last bit of a word is on the pins keeps the stream gapless.
    assign ready_c      = active && (bits_left_q <= LEFT_W'(1))
                          && (bits_queued_q != TOTAL_W'(CHAIN_LENGTH));
    assign accept_c     = word_valid && ready_c;
    assign last_shift_c = shift_en && (bits_total_q == TOTAL_W'(CHAIN_LENGTH - 1));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            word_q        <= '0;
            bits_left_q   <= '0;
            bits_queued_q <= '0;
            bits_total_q  <= '0;
            shift_bit     <= 1'b0;
            shift_en      <= 1'b0;
        end else if (clear) begin
            word_q        <= '0;
            bits_left_q   <= '0;
            bits_queued_q <= '0;
            bits_total_q  <= '0;
            shift_en      <= 1'b0;
        end else if (!active) begin
            shift_en <= 1'b0;
        end else begin
            if (shift_en) begin
                bits_total_q <= bits_total_q + TOTAL_W'(1);
            end
            if (accept_c) begin
                shift_en      <= 1'b1;
                shift_bit     <= word_data[0];
                word_q        <= word_data >> 1;
                bits_left_q   <= take_c;
                bits_queued_q <= bits_queued_q + TOTAL_W'(take_c);
            end else if (bits_left_q > LEFT_W'(1)) begin
                shift_en    <= 1'b1;
                shift_bit   <= word_q[0];
                word_q      <= word_q >> 1;
                bits_left_q <= bits_left_q - LEFT_W'(1);
            end else begin
                // Stall: data pin keeps its last value.
                shift_en    <= 1'b0;
                bits_left_q <= '0;
            end
        end
    end

endmodule

// File: rtl/config_loader.sv
// Configuration bitstream loader: host words in, serial chain data and shift enable out.
// Define CONFIG_LOADER_VERIFY_EN to add a parity-checked recirculation pass after each load.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned CHAIN_LENGTH = CONFIG_BITS_PER_TILE
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data_out,
    output logic                  chain_enable,
    input  logic                  chain_data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_LOAD   = 2'(ST_LOAD);
    localparam logic [1:0] S_DONE   = 2'(ST_DONE);
`ifdef CONFIG_LOADER_VERIFY_EN
    localparam logic [1:0] S_VERIFY = 2'(ST_VERIFY);
    localparam int unsigned TOTAL_W = $clog2(CHAIN_LENGTH + 1);
`endif

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       busy_d;
    logic       done_d;
    logic       start_load_c;
    logic       loading_c;
    logic       ser_ready_c;
    logic       ser_bit;
    logic       ser_en;
    logic       last_shift_c;

    assign loading_c = (state_q == S_LOAD);

    config_word_serializer #(
        .WORD_WIDTH   (WORD_WIDTH),
        .CHAIN_LENGTH (CHAIN_LENGTH)
    ) u_serializer (
        .clock        (clock),
        .nreset       (nreset),
        .clear        (start_load_c),
        .active       (loading_c),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .ready_c      (ser_ready_c),
        .shift_bit    (ser_bit),
        .shift_en     (ser_en),
        .last_shift_c (last_shift_c)
    );

    assign word_ready = ser_ready_c;

`ifdef CONFIG_LOADER_VERIFY_EN
    logic [TOTAL_W-1:0] verify_cnt_q;
    logic               load_par_q;
    logic               verify_par_q;
    logic               error_d;
    logic               verifying_c;
    logic               verify_last_c;

    assign verifying_c   = (state_q == S_VERIFY);
    assign verify_last_c = verifying_c && (verify_cnt_q == TOTAL_W'(CHAIN_LENGTH - 1));

    // During verify the chain tail feeds straight back into its head for one revolution.
    assign chain_enable   = ser_en | verifying_c;
    assign chain_data_out = verifying_c ? chain_data_in : ser_bit;
`else
    logic unused_chain_data_in;

    assign unused_chain_data_in = chain_data_in;
    assign chain_enable         = ser_en;
    assign chain_data_out       = ser_bit;
    assign error                = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        start_load_c = 1'b0;
`ifdef CONFIG_LOADER_VERIFY_EN
        error_d      = error;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    start_load_c = 1'b1;
`ifdef CONFIG_LOADER_VERIFY_EN
                    error_d      = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (last_shift_c) begin
`ifdef CONFIG_LOADER_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CONFIG_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (verify_last_c) begin
                    state_d = S_DONE;
                    error_d = load_par_q ^ verify_par_q ^ chain_data_in;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

`ifdef CONFIG_LOADER_VERIFY_EN
    // Parity of the loaded stream versus parity seen coming back off the chain tail.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            error        <= 1'b0;
            load_par_q   <= 1'b0;
            verify_par_q <= 1'b0;
            verify_cnt_q <= '0;
        end else begin
            error <= error_d;
            if (start_load_c) begin
                load_par_q   <= 1'b0;
                verify_par_q <= 1'b0;
                verify_cnt_q <= '0;
            end else begin
                if (ser_en) begin
                    load_par_q <= load_par_q ^ ser_bit;
                end
                if (verifying_c) begin
                    verify_par_q <= verify_par_q ^ chain_data_in;
                    verify_cnt_q <= verify_cnt_q + TOTAL_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_config_loader.sv
// Randomised bench for config_loader with a behavioural tile-chain model and stream reference.
module tb_config_loader;
    import config_loader_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned CL = CONFIG_BITS_PER_TILE;
    localparam int unsigned NW = (CL + W - 1) / W;
`ifdef CONFIG_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clock;
    logic          nreset;
    logic          start;
    logic [W-1:0]  word_data;
    logic          word_valid;
    logic          word_ready;
    logic          chain_data_out;
    logic          chain_enable;
    logic          chain_data_in;
    logic          busy;
    logic          done;
    logic          error;

    logic [CL-1:0] chain_m;
    logic [CL-1:0] chain_f;
    logic [CL-1:0] flip_mask;

    int checks = 0;
    int passed = 0;

    config_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(CL)) dut (
        .clock          (clock),
        .nreset         (nreset),
        .start          (start),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .chain_data_out (chain_data_out),
        .chain_enable   (chain_enable),
        .chain_data_in  (chain_data_in),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Tile chain: head at position 0, tail at CL-1 returns to the loader.
    assign chain_f       = chain_m ^ flip_mask;
    assign chain_data_in = chain_m[CL-1];
    always @(posedge clock) begin
        if (chain_enable) chain_m <= {chain_f[CL-2:0], chain_data_out};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_load(input logic [W-1:0] words [NW], input int gaps [NW],
                            input int start_at, input int reset_at,
                            input bit do_flip, input int flip_idx, input string tag);
        logic [CL-1:0] exp_stream, obs_stream, exp_chain, mask;
        logic [W-1:0]  wtmp;
        logic          prev_data, exp_err;
        int c, en_cnt, hs, done_cnt, done_cyc, last_en, first_en;
        int stall_run, max_stall, stall_bad, idx, gap_left, sum_gaps, max_gap;
        bit finished, aborted;

        exp_stream = '0; obs_stream = '0; exp_chain = '0; mask = '0;
        for (int k = 0; k < CL; k++) begin
            wtmp = words[k / W];
            exp_stream[k] = wtmp[k % W];
        end
        for (int k = 0; k < CL; k++) exp_chain[CL-1-k] = exp_stream[k];
        if (do_flip) mask[flip_idx] = 1'b1;
        exp_err = VERIFY ? ((^exp_stream) ^ (^(exp_chain ^ mask))) : 1'b0;
        sum_gaps = 0; max_gap = 0;
        for (int i = 0; i < NW; i++) begin
            sum_gaps += gaps[i];
            if (i > 0 && gaps[i] > max_gap) max_gap = gaps[i];
        end

        c = 1; en_cnt = 0; hs = 0; done_cnt = 0; done_cyc = -1; last_en = -100; first_en = -1;
        stall_run = 0; max_stall = 0; stall_bad = 0; idx = 0; gap_left = gaps[0];
        finished = 0; aborted = 0; prev_data = 1'b0;

        start = 1'b1; word_valid = 1'b0;
        step();
        start = 1'b0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        check({tag, "_err_clear"}, 64'(error), 64'd0);

        while (!finished && !aborted && c < 3000) begin
            if (chain_enable) begin
                if (en_cnt < CL) obs_stream[en_cnt] = chain_data_out;
                en_cnt++;
                if (en_cnt == 1) first_en = c;
                if (en_cnt == CL) last_en = c;
                if (stall_run > max_stall) max_stall = stall_run;
                stall_run = 0;
            end else if (en_cnt > 0 && en_cnt < CL) begin
                stall_run++;
                if (chain_data_out !== prev_data) stall_bad++;
            end
            prev_data = chain_data_out;

            if (done) begin
                done_cnt++;
                done_cyc = c;
                finished = 1;
                check({tag, "_err_done"}, 64'(error), 64'(exp_err));
                check({tag, "_busy_done"}, 64'(busy), 64'd0);
                word_valid = 1'b0;
                start = 1'b0;
            end else if (reset_at > 0 && chain_enable && en_cnt == reset_at) begin
                nreset = 1'b0;
                #1;
                check({tag, "_reset_outs"},
                      64'({word_ready, chain_data_out, chain_enable, busy, done, error}), 64'd0);
                word_valid = 1'b0;
                step();
                nreset = 1'b1;
                step();
                check({tag, "_reset_idle"}, 64'({busy, chain_enable, word_ready}), 64'd0);
                aborted = 1;
            end else begin
                start = (c == start_at);
                if (idx < NW) begin
                    if (gap_left > 0) begin
                        word_valid = word_ready ? 1'b0 : 1'($urandom_range(0, 1));
                        word_data  = W'($urandom);
                        if (word_ready) gap_left--;
                    end else begin
                        word_valid = 1'b1;
                        word_data  = words[idx];
                    end
                end else begin
                    word_valid = 1'($urandom_range(0, 1));
                    word_data  = W'($urandom);
                end
                if (word_valid && word_ready) begin
                    hs++;
                    idx++;
                    gap_left = (idx < NW) ? gaps[idx] : 0;
                end
                if (do_flip && c == last_en + 1) flip_mask = mask;
                step();
                flip_mask = '0;
                start = 1'b0;
                c++;
            end
        end

        if (!aborted) begin
            check({tag, "_finished"}, 64'(finished), 64'd1);
            for (int i = 0; i < 3; i++) begin
                step();
                if (done) done_cnt++;
                check({tag, "_err_hold"}, 64'(error), 64'(exp_err));
            end
            check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
            check({tag, "_handshakes"}, 64'(hs), 64'(NW));
            check({tag, "_enables"}, 64'(en_cnt), 64'(VERIFY ? 2 * CL : CL));
            check({tag, "_stream"}, 64'(obs_stream), 64'(exp_stream));
            check({tag, "_chain"}, 64'(chain_m), 64'(exp_chain ^ mask));
            check({tag, "_done_lat"}, 64'(done_cyc - last_en), 64'(VERIFY ? CL + 1 : 1));
            check({tag, "_load_len"}, 64'(last_en), 64'(CL + 1 + sum_gaps));
            check({tag, "_stall_len"}, 64'(max_stall), 64'(max_gap));
            check({tag, "_stall_hold"}, 64'(stall_bad), 64'd0);
            if (gaps[0] == 0) check({tag, "_first_shift"}, 64'(first_en), 64'd2);
        end
        word_valid = 1'b0;
        step();
        step();
    endtask

    logic [W-1:0] wv [NW];
    int           gv [NW];

    initial begin
        nreset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0; flip_mask = '0;
        #1 nreset = 1'b0;
        step();
        step();
        check("reset_state", 64'({word_ready, chain_data_out, chain_enable, busy, done, error}), 64'd0);
        nreset = 1'b1;
        step();

        wv = '{8'hA5, 8'h3C, 8'hFF, 8'h1F};
        gv = '{0, 0, 0, 0};
        run_load(wv, gv, -1, -1, 1'b0, 0, "basic");

        gv = '{0, 0, 5, 0};
        run_load(wv, gv, -1, -1, 1'b0, 0, "stall5");

        gv = '{0, 0, 0, 0};
        run_load(wv, gv, 10, -1, 1'b0, 0, "start_busy");

        for (int i = 0; i < NW; i++) wv[i] = W'($urandom);
        run_load(wv, gv, -1, 12, 1'b0, 0, "reset_mid");
        for (int i = 0; i < NW; i++) wv[i] = W'($urandom);
        run_load(wv, gv, -1, -1, 1'b0, 0, "after_reset");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) begin
                wv[i] = W'($urandom);
                gv[i] = int'($urandom_range(0, 3));
            end
            run_load(wv, gv, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : -1,
                     -1, 1'b0, 0, $sformatf("rand%0d", r));
        end

`ifdef CONFIG_LOADER_VERIFY_EN
        gv = '{0, 0, 0, 0};
        for (int i = 0; i < NW; i++) wv[i] = W'($urandom);
        run_load(wv, gv, -1, -1, 1'b1, int'($urandom_range(0, CL - 2)), "verify_flip");
        run_load(wv, gv, -1, -1, 1'b0, 0, "after_flip");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
